// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: Avalon-style read port toward memory plus the
// instruction/redirect handshake toward decode.
interface instr_fetch_if;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  instr_opcode;
  logic [31:0] instr_pc;
  logic        halted;
  logic        fault;

  modport master (
    output mem_address, mem_read, instr_valid, instr, instr_opcode, instr_pc, halted, fault,
    input  mem_waitrequest, mem_readdata, stall, redirect_valid, redirect_target
  );

  modport slave (
    input  mem_address, mem_read, instr_valid, instr, instr_opcode, instr_pc, halted, fault,
    output mem_waitrequest, mem_readdata, stall, redirect_valid, redirect_target
  );
endinterface

// File: rtl/instr_fetch.sv
// MIPS instruction fetch: owns the PC, reads memory with waitrequest, and
// hands each word to decode under valid/stall with redirect, halt and fault.
module instr_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_HOLD,
    S_HALTED,
    S_FAULT
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] fetch_addr_q;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        discard_q;
  logic        instr_valid_q;
  logic        halted_q;
  logic        fault_q;
  logic        mem_read_q;

  logic        redir_ok;
  logic        redir_bad;
  logic [31:0] pc_eff;
  logic        resume_halt;

  // pc_eff is the PC that any departure this cycle resumes from.
  always_comb begin
    redir_ok    = bus.redirect_valid && (bus.redirect_target[1:0] == 2'b00);
    redir_bad   = bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00);
    pc_eff      = redir_ok ? bus.redirect_target : pc_q;
    resume_halt = (pc_eff == HALT_ADDR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_VECTOR;
      fetch_addr_q  <= RESET_VECTOR;
      discard_q     <= 1'b0;
      instr_q       <= 32'h0;
      instr_pc_q    <= 32'h0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
      mem_read_q    <= 1'b0;
    end else begin
      case (state_q)
        S_BOOT: begin
          if (redir_bad) begin
            state_q <= S_FAULT;
            fault_q <= 1'b1;
          end else begin
            pc_q <= pc_eff;
            if (resume_halt) begin
              state_q  <= S_HALTED;
              halted_q <= 1'b1;
            end else begin
              state_q      <= S_FETCH;
              fetch_addr_q <= pc_eff;
              mem_read_q   <= 1'b1;
            end
          end
        end

        S_FETCH: begin
          if (fault_q) begin
            // Misaligned redirect already seen: finish the bus cycle, then stop.
            if (!bus.mem_waitrequest) begin
              state_q    <= S_FAULT;
              mem_read_q <= 1'b0;
            end
          end else if (redir_bad) begin
            fault_q       <= 1'b1;
            instr_valid_q <= 1'b0;
            if (!bus.mem_waitrequest) begin
              state_q    <= S_FAULT;
              mem_read_q <= 1'b0;
            end
          end else if (bus.mem_waitrequest) begin
            if (redir_ok) begin
              pc_q      <= bus.redirect_target;
              discard_q <= 1'b1;
            end
          end else if (redir_ok || discard_q) begin
            discard_q <= 1'b0;
            pc_q      <= pc_eff;
            if (resume_halt) begin
              state_q    <= S_HALTED;
              halted_q   <= 1'b1;
              mem_read_q <= 1'b0;
            end else begin
              fetch_addr_q <= pc_eff;
            end
          end else begin
            instr_q       <= bus.mem_readdata;
            instr_pc_q    <= fetch_addr_q;
            instr_valid_q <= 1'b1;
            pc_q          <= fetch_addr_q + 32'd4;
            state_q       <= S_HOLD;
            mem_read_q    <= 1'b0;
          end
        end

        S_HOLD: begin
          if (redir_bad) begin
            state_q       <= S_FAULT;
            fault_q       <= 1'b1;
            instr_valid_q <= 1'b0;
          end else if (redir_ok || !bus.stall) begin
            // A redirect flushes the held word even if decode takes it this cycle.
            instr_valid_q <= 1'b0;
            pc_q          <= pc_eff;
            if (resume_halt) begin
              state_q  <= S_HALTED;
              halted_q <= 1'b1;
            end else begin
              state_q      <= S_FETCH;
              fetch_addr_q <= pc_eff;
              mem_read_q   <= 1'b1;
            end
          end
        end

        S_HALTED, S_FAULT: begin
          mem_read_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end

        default: begin
          state_q    <= S_BOOT;
          mem_read_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_address  = fetch_addr_q;
  assign bus.mem_read     = mem_read_q;
  assign bus.instr_valid  = instr_valid_q;
  assign bus.instr        = instr_q;
  assign bus.instr_opcode = instr_q[31:26];
  assign bus.instr_pc     = instr_pc_q;
  assign bus.halted       = halted_q;
  assign bus.fault        = fault_q;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage for the MIPS core; sits directly upstream of the main control decoder.
- Owns the PC and issues reads on an Avalon-style memory port with waitrequest.
- Latches each returned word and presents it, with its opcode field and PC, to decode under a valid/stall handshake.
- Applies branch/jump redirects from downstream; detects halt (fetch of HALT_ADDR) and misaligned targets.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC loaded on reset.
- HALT_ADDR, 32'h00000000, next-PC value that halts fetch instead of issuing a read.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- mem_address  out  32  read address; equals fetch_addr register.
- mem_read  out  1  read request; high only in FETCH state.
- mem_waitrequest  in  1  high = read not yet complete; address/read must be held stable.
- mem_readdata  in  32  read data, valid in the cycle mem_read=1 and mem_waitrequest=0.
- stall  in  1  decode cannot accept this cycle.
- redirect_valid  in  1  one-cycle pulse: replace PC with redirect_target.
- redirect_target  in  32  new PC.
- instr_valid  out  1  instr/instr_pc/instr_opcode hold a live instruction.
- instr  out  32  latched instruction word.
- instr_opcode  out  6  instr[31:26], combinational from instr.
- instr_pc  out  32  address the instruction was fetched from.
- halted  out  1  sticky; fetch stopped at HALT_ADDR.
- fault  out  1  sticky; misaligned redirect target.

Behaviour:
- Registers: pc (next address to fetch), fetch_addr (address of outstanding read), discard flag, state.
- Reset (rst_n=0 at edge):
  - state=BOOT, pc=RESET_VECTOR, fetch_addr=RESET_VECTOR, discard=0.
  - instr=0, instr_pc=0, instr_valid=0, halted=0, fault=0, mem_read=0.
  - Reset mid-transaction abandons the read; no data is latched.
- BOOT: mem_read=0. Next cycle goes to FETCH with fetch_addr=pc.
- FETCH: mem_read=1, mem_address=fetch_addr, held stable while mem_waitrequest=1.
  - On mem_waitrequest=0 with discard=0 and no redirect this cycle:
    - instr<=mem_readdata; instr_pc<=fetch_addr; instr_valid<=1; pc<=fetch_addr+4 (mod 2^32).
    - Go to HOLD.
  - On mem_waitrequest=0 with discard=1: drop the data, clear discard. Next cycle go to FETCH with fetch_addr=pc, or to HALTED if pc==HALT_ADDR.
- HOLD: mem_read=0; outputs stable.
  - Accept = instr_valid & ~stall at an edge.
  - On accept: instr_valid<=0. Next state is HALTED if pc==HALT_ADDR; otherwise FETCH with fetch_addr<=pc.
  - stall=1 holds all outputs indefinitely.
- Redirect (redirect_valid=1), highest priority:
  - Aligned target (redirect_target[1:0]==0):
    - pc<=target.
    - In HOLD: instr_valid<=0 (flush, even if accept also occurs in the same cycle); next state as for accept, using the new pc.
    - In FETCH with mem_waitrequest=1: set discard=1; the read completes at the old address and its data is dropped.
    - In FETCH with mem_waitrequest=0: data dropped; next cycle FETCH at target, or HALTED if target==HALT_ADDR.
  - Misaligned target:
    - Go to FAULT; fault<=1; instr_valid<=0.
    - An outstanding read is still completed and discarded before mem_read drops.
- HALTED / FAULT:
  - mem_read=0, instr_valid=0, halted=1 or fault=1.
  - Terminal until reset; redirect_valid and stall are ignored.
- Timing:
  - Data is returned in cycle N with waitrequest=0; instr_valid is high from N+1.
  - Zero-wait memory with stall=0 gives one instruction per 2 cycles.
- No read is issued to HALT_ADDR.

Test Plan:
- Boot with rst_n low 2 cycles, zero-wait memory returning 32'h8C010004:
  - First mem_address=BFC00000.
  - Next cycle: instr_valid=1, instr_opcode=6'b100011, instr_pc=BFC00000.
  - Next fetch address=BFC00004.
- Waitrequest held 3 cycles on fetch of BFC00004:
  - mem_address/mem_read stable for all 4 cycles.
  - instr_valid rises exactly 1 cycle after waitrequest falls.
- stall=1 for 5 cycles with instr_valid=1:
  - instr and instr_pc unchanged; mem_read=0 throughout.
  - Next fetch only after stall drops.
- redirect_valid to BFC00100 while a read is waiting:
  - Old read completes and is discarded (instr_valid stays 0).
  - Next mem_address=BFC00100; instr_pc of the next valid instruction is BFC00100.
- Redirect to 00000000:
  - halted=1; mem_read never asserts again.
  - Later redirects are ignored until rst_n pulses low, after which fetch restarts at BFC00000.
- Redirect to BFC00102:
  - fault=1, instr_valid=0, no further reads.
  - Also drive rst_n low mid-FETCH: all outputs return to reset values at the next edge.
